// File: rtl/cache_arb_pkg.sv
// Shared types for the L1-to-L2 request arbiter: FSM state and grant owner.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/l2_arb_mux.sv
// Combinational steering between the two L1 request ports and the single L2 port.
module l2_arb_mux
    import cache_arb_pkg::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              active_i,
    input  grant_t            gnt_i,
    input  logic              icache_read_i,
    input  logic              icache_write_i,
    input  logic [s_addr-1:0] icache_address_i,
    input  logic [s_line-1:0] icache_wdata_i,
    input  logic              dcache_read_i,
    input  logic              dcache_write_i,
    input  logic [s_addr-1:0] dcache_address_i,
    input  logic [s_line-1:0] dcache_wdata_i,
    input  logic              l2_resp_i,
    output logic              l2_read_o,
    output logic              l2_write_o,
    output logic [s_addr-1:0] l2_address_o,
    output logic [s_line-1:0] l2_wdata_o,
    output logic              icache_resp_o,
    output logic              dcache_resp_o
);

    always_comb begin
        l2_read_o     = 1'b0;
        l2_write_o    = 1'b0;
        l2_address_o  = '0;
        l2_wdata_o    = '0;
        icache_resp_o = 1'b0;
        dcache_resp_o = 1'b0;
        if (active_i) begin
            if (gnt_i == GNT_D) begin
                l2_read_o     = dcache_read_i;
                l2_write_o    = dcache_write_i;
                l2_address_o  = dcache_address_i;
                l2_wdata_o    = dcache_wdata_i;
                dcache_resp_o = l2_resp_i;
            end else begin
                l2_read_o     = icache_read_i;
                l2_write_o    = icache_write_i;
                l2_address_o  = icache_address_i;
                l2_wdata_o    = icache_wdata_i;
                icache_resp_o = l2_resp_i;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the L2 upstream port between icache and dcache; one owner at a time,
// grant held until L2 resp, round-robin (or dcache-priority) on ties.
module l2_request_arbiter
    import cache_arb_pkg::*;
#(
    parameter int s_line      = 256,
    parameter int s_addr      = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_icache_read,
    input  logic              l2_icache_write,
    input  logic [s_addr-1:0] l2_icache_address,
    input  logic [s_line-1:0] l2_icache_wdata,
    output logic              l2_icache_resp,
    output logic [s_line-1:0] l2_icache_rdata,
    input  logic              l2_dcache_read,
    input  logic              l2_dcache_write,
    input  logic [s_addr-1:0] l2_dcache_address,
    input  logic [s_line-1:0] l2_dcache_wdata,
    output logic              l2_dcache_resp,
    output logic [s_line-1:0] l2_dcache_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_address,
    output logic [s_line-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [s_line-1:0] l2_rdata
);

    arb_state_t arb_state_q, arb_state_d;
    grant_t     last_grant_q, last_grant_d;

    logic   req_icache, req_dcache;
    logic   tie_to_d;
    logic   serving;
    grant_t gnt;

    assign req_icache = l2_icache_read | l2_icache_write;
    assign req_dcache = l2_dcache_read | l2_dcache_write;
    assign tie_to_d   = (last_grant_q == GNT_I) || !ROUND_ROBIN;

    always_comb begin
        arb_state_d  = arb_state_q;
        last_grant_d = last_grant_q;
        case (arb_state_q)
            IDLE: begin
                if (req_icache && req_dcache) arb_state_d = tie_to_d ? SERVE_D : SERVE_I;
                else if (req_icache)          arb_state_d = SERVE_I;
                else if (req_dcache)          arb_state_d = SERVE_D;
            end
            SERVE_I: begin
                if (l2_resp) begin
                    arb_state_d  = IDLE;
                    last_grant_d = GNT_I;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    arb_state_d  = IDLE;
                    last_grant_d = GNT_D;
                end
            end
            default: arb_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state_q  <= IDLE;
            last_grant_q <= GNT_D;
        end else begin
            arb_state_q  <= arb_state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Reset is synchronous, so the state may still read SERVE_x while rst is
    // high; gate the outputs directly so the L2 sees nothing during reset.
    assign serving = !rst && (arb_state_q != IDLE);
    assign gnt     = (arb_state_q == SERVE_D) ? GNT_D : GNT_I;

    assign l2_icache_rdata = rst ? '0 : l2_rdata;
    assign l2_dcache_rdata = rst ? '0 : l2_rdata;

    l2_arb_mux #(
        .s_line (s_line),
        .s_addr (s_addr)
    ) u_mux (
        .active_i         (serving),
        .gnt_i            (gnt),
        .icache_read_i    (l2_icache_read),
        .icache_write_i   (l2_icache_write),
        .icache_address_i (l2_icache_address),
        .icache_wdata_i   (l2_icache_wdata),
        .dcache_read_i    (l2_dcache_read),
        .dcache_write_i   (l2_dcache_write),
        .dcache_address_i (l2_dcache_address),
        .dcache_wdata_i   (l2_dcache_wdata),
        .l2_resp_i        (l2_resp),
        .l2_read_o        (l2_read),
        .l2_write_o       (l2_write),
        .l2_address_o     (l2_address),
        .l2_wdata_o       (l2_wdata),
        .icache_resp_o    (l2_icache_resp),
        .dcache_resp_o    (l2_dcache_resp)
    );

    // Protocol checks: granted L1 must hold its request, no read+write
    // together, and the L2 must never respond with nothing outstanding.
    a_hold_i: assert property (@(posedge clk) disable iff (rst)
        (arb_state_q == SERVE_I) |-> req_icache);
    a_hold_d: assert property (@(posedge clk) disable iff (rst)
        (arb_state_q == SERVE_D) |-> req_dcache);
    a_rw_i: assert property (@(posedge clk) disable iff (rst)
        !(l2_icache_read && l2_icache_write));
    a_rw_d: assert property (@(posedge clk) disable iff (rst)
        !(l2_dcache_read && l2_dcache_write));
    a_idle_resp: assert property (@(posedge clk) disable iff (rst)
        (arb_state_q == IDLE) |-> !l2_resp);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized + directed bench for l2_request_arbiter against a transaction-level owner model.
module tb_l2_request_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam bit RR = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          l2_icache_read, l2_icache_write, l2_icache_resp;
    logic [AW-1:0] l2_icache_address;
    logic [LW-1:0] l2_icache_wdata, l2_icache_rdata;
    logic          l2_dcache_read, l2_dcache_write, l2_dcache_resp;
    logic [AW-1:0] l2_dcache_address;
    logic [LW-1:0] l2_dcache_wdata, l2_dcache_rdata;
    logic          l2_read, l2_write, l2_resp;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata, l2_rdata;

    l2_request_arbiter #(.s_line(LW), .s_addr(AW), .ROUND_ROBIN(RR)) dut (
        .clk(clk), .rst(rst),
        .l2_icache_read(l2_icache_read), .l2_icache_write(l2_icache_write),
        .l2_icache_address(l2_icache_address), .l2_icache_wdata(l2_icache_wdata),
        .l2_icache_resp(l2_icache_resp), .l2_icache_rdata(l2_icache_rdata),
        .l2_dcache_read(l2_dcache_read), .l2_dcache_write(l2_dcache_write),
        .l2_dcache_address(l2_dcache_address), .l2_dcache_wdata(l2_dcache_wdata),
        .l2_dcache_resp(l2_dcache_resp), .l2_dcache_rdata(l2_dcache_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata)
    );

    // Second instance with dcache priority on ties.
    logic          f_rst, f_i_read, f_i_write, f_i_resp, f_d_read, f_d_write, f_d_resp;
    logic [AW-1:0] f_i_addr, f_d_addr, f_l2_address;
    logic [LW-1:0] f_i_wdata, f_d_wdata, f_i_rdata, f_d_rdata, f_l2_wdata, f_l2_rdata;
    logic          f_l2_read, f_l2_write, f_l2_resp;

    l2_request_arbiter #(.s_line(LW), .s_addr(AW), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .rst(f_rst),
        .l2_icache_read(f_i_read), .l2_icache_write(f_i_write),
        .l2_icache_address(f_i_addr), .l2_icache_wdata(f_i_wdata),
        .l2_icache_resp(f_i_resp), .l2_icache_rdata(f_i_rdata),
        .l2_dcache_read(f_d_read), .l2_dcache_write(f_d_write),
        .l2_dcache_address(f_d_addr), .l2_dcache_wdata(f_d_wdata),
        .l2_dcache_resp(f_d_resp), .l2_dcache_rdata(f_d_rdata),
        .l2_read(f_l2_read), .l2_write(f_l2_write), .l2_address(f_l2_address),
        .l2_wdata(f_l2_wdata), .l2_resp(f_l2_resp), .l2_rdata(f_l2_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stimulus state (what each L1 / the L2 drive) and the owner model.
    logic          rd[2], wr[2], got_resp[2];
    logic [AW-1:0] ad[2];
    logic [LW-1:0] wd[2];
    logic          rst_v, resp_v;
    logic [LW-1:0] rdata_v;
    int            own;       // -1 nobody, 0 icache, 1 dcache
    int            last;      // side served most recently
    int            l2_cnt, l2_tgt;
    int            dlog[$];   // sides observed on the L2 port, in order
    logic          vis_prev;

    function automatic logic [LW-1:0] rline();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        logic          e_rd, e_wr, vis;
        logic [AW-1:0] e_ad;
        logic [LW-1:0] e_wd, e_rdata;
        logic          e_resp[2];
        logic          rq0, rq1;
        @(negedge clk);
        rst = rst_v;
        l2_icache_read = rd[0]; l2_icache_write = wr[0];
        l2_icache_address = ad[0]; l2_icache_wdata = wd[0];
        l2_dcache_read = rd[1]; l2_dcache_write = wr[1];
        l2_dcache_address = ad[1]; l2_dcache_wdata = wd[1];
        l2_resp = resp_v; l2_rdata = rdata_v;
        #1;
        e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_wd = '0;
        e_resp[0] = 1'b0; e_resp[1] = 1'b0;
        if (!rst_v && own >= 0) begin
            e_rd = rd[own]; e_wr = wr[own]; e_ad = ad[own]; e_wd = wd[own];
            e_resp[own] = resp_v;
        end
        e_rdata = rst_v ? '0 : rdata_v;
        chk("l2_read",  LW'(l2_read),  LW'(e_rd));
        chk("l2_write", LW'(l2_write), LW'(e_wr));
        chk("l2_addr",  LW'(l2_address), LW'(e_ad));
        chk("l2_wdata", l2_wdata, e_wd);
        chk("i_resp",   LW'(l2_icache_resp), LW'(e_resp[0]));
        chk("d_resp",   LW'(l2_dcache_resp), LW'(e_resp[1]));
        chk("i_rdata",  l2_icache_rdata, e_rdata);
        chk("d_rdata",  l2_dcache_rdata, e_rdata);
        vis = l2_read | l2_write;
        if (vis && !vis_prev) dlog.push_back((l2_address == ad[1]) ? 1 : 0);
        vis_prev = vis;
        got_resp[0] = e_resp[0];
        got_resp[1] = e_resp[1];
        // Advance the owner model across the coming clock edge.
        rq0 = rd[0] | wr[0];
        rq1 = rd[1] | wr[1];
        if (rst_v) begin
            own = -1; last = 1;
        end else if (own < 0) begin
            if (rq0 && rq1) own = (last == 0 || !RR) ? 1 : 0;
            else if (rq0)   own = 0;
            else if (rq1)   own = 1;
            l2_cnt = 0;
            l2_tgt = int'($urandom_range(3));
        end else if (resp_v) begin
            last = own; own = -1;
        end else begin
            l2_cnt++;
        end
    endtask

    task automatic rand_drive(input int p, input bit allow_rst);
        bit w;
        for (int s = 0; s < 2; s++) begin
            if (got_resp[s] || rst_v) begin rd[s] = 1'b0; wr[s] = 1'b0; end
            if (!(rd[s] | wr[s]) && int'($urandom_range(99)) < p) begin
                w = (s == 1) ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
                rd[s] = !w; wr[s] = w;
                ad[s] = $urandom; wd[s] = rline();
            end
        end
        rst_v   = allow_rst && ($urandom_range(299) == 0);
        resp_v  = (own >= 0) && (l2_cnt >= l2_tgt);
        rdata_v = rline();
    endtask

    task automatic clear_l1();
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0; got_resp[s] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1; resp_v = 1'b0;
        clear_l1();
        step(); step();
        rst_v = 1'b0;
    endtask

    logic [LW-1:0] beef, five_a;
    int n;
    bit hit_prev;

    initial begin
        beef = {8{32'hDEADBEEF}};
        five_a = {8{32'h5A5A5A5A}};
        own = -1; last = 1; l2_cnt = 0; l2_tgt = 0; vis_prev = 1'b0;
        rdata_v = rline();
        f_rst = 1'b1; f_i_read = 1'b0; f_i_write = 1'b0; f_i_addr = '0; f_i_wdata = '0;
        f_d_read = 1'b0; f_d_write = 1'b0; f_d_addr = '0; f_d_wdata = '0;
        f_l2_resp = 1'b0; f_l2_rdata = '0;

        // Reset with a request pending: outputs stay quiet.
        clear_l1();
        rst_v = 1'b1; resp_v = 1'b0;
        rd[0] = 1'b1; ad[0] = 32'h0000_0040;
        step();
        chk("rst_read", LW'(l2_read), LW'(1'b0));
        chk("rst_rdata", l2_icache_rdata, LW'(0));
        do_reset();

        // Icache only, L2 answers after 5 cycles with DEADBEEF data.
        rd[0] = 1'b1; ad[0] = 32'h0000_1040;
        step();
        chk("tp1_idle", LW'(l2_read), LW'(1'b0));
        for (int c = 0; c < 5; c++) begin
            step();
            chk("tp1_read", LW'(l2_read), LW'(1'b1));
            chk("tp1_addr", LW'(l2_address), LW'(32'h0000_1040));
        end
        resp_v = 1'b1; rdata_v = beef;
        step();
        chk("tp1_iresp", LW'(l2_icache_resp), LW'(1'b1));
        chk("tp1_idata", l2_icache_rdata, beef);
        chk("tp1_dresp", LW'(l2_dcache_resp), LW'(1'b0));
        resp_v = 1'b0; clear_l1();
        step();
        chk("tp1_pulse", LW'(l2_icache_resp), LW'(1'b0));

        // Simultaneous after reset: icache first, one IDLE, then dcache write.
        do_reset();
        rd[0] = 1'b1; ad[0] = 32'h100;
        wr[1] = 1'b1; ad[1] = 32'h200; wd[1] = five_a;
        step();
        step();
        chk("tp2_iaddr", LW'(l2_address), LW'(32'h100));
        resp_v = 1'b1;
        step();
        rd[0] = 1'b0; resp_v = 1'b0;
        step();
        chk("tp2_gap", LW'(l2_write), LW'(1'b0));
        step();
        chk("tp2_write", LW'(l2_write), LW'(1'b1));
        chk("tp2_daddr", LW'(l2_address), LW'(32'h200));
        chk("tp2_wdata", l2_wdata, five_a);
        resp_v = 1'b1;
        step();
        resp_v = 1'b0; clear_l1();
        step();

        // Reset in the third cycle of SERVE_D, then a normal icache grant.
        do_reset();
        rd[1] = 1'b1; ad[1] = 32'h0000_2000;
        step(); step(); step();
        rst_v = 1'b1;
        step();
        chk("rmid_read", LW'(l2_read), LW'(1'b0));
        chk("rmid_addr", LW'(l2_address), LW'(0));
        rst_v = 1'b0; clear_l1();
        rd[0] = 1'b1; ad[0] = 32'h0000_3000;
        step();
        chk("rpost_idle", LW'(l2_read), LW'(1'b0));
        step();
        chk("rpost_read", LW'(l2_read), LW'(1'b1));
        chk("rpost_addr", LW'(l2_address), LW'(32'h0000_3000));
        resp_v = 1'b1;
        step();
        resp_v = 1'b0; clear_l1();
        step();

        // Sustained contention: order must be I,D,I,D,I,D.
        do_reset();
        dlog.delete();
        for (int c = 0; c < 300 && dlog.size() < 6; c++) begin
            rand_drive(100, 1'b0);
            step();
        end
        chk("rr_count", LW'(dlog.size() >= 6), LW'(1'b1));
        for (int i = 0; i < 6 && i < dlog.size(); i++)
            chk("rr_order", LW'(dlog[i]), LW'(i % 2));

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rand_drive(30, 1'b1);
            step();
        end
        do_reset();

        // Dcache-priority instance: dcache wins every tie, 0-wait resp.
        f_i_read = 1'b1; f_i_addr = 32'h100;
        f_d_read = 1'b1; f_d_addr = 32'h200;
        @(negedge clk); @(negedge clk);
        f_rst = 1'b0;
        n = 0; hit_prev = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            f_l2_resp = 1'b0; f_l2_rdata = rline();
            #1;
            if (hit_prev) chk("rr0_idle", LW'(f_l2_read), LW'(1'b0));
            hit_prev = 1'b0;
            if (f_l2_read | f_l2_write) begin
                chk("rr0_addr", LW'(f_l2_address), LW'(32'h200));
                f_l2_resp = 1'b1;
                #1;
                chk("rr0_dresp", LW'(f_d_resp), LW'(1'b1));
                chk("rr0_iresp", LW'(f_i_resp), LW'(1'b0));
                chk("rr0_drdata", f_d_rdata, f_l2_rdata);
                n++;
                hit_prev = 1'b1;
            end
        end
        chk("rr0_count", LW'(n), LW'(6));
        @(negedge clk);
        f_l2_resp = 1'b0; f_rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
